alu_cmd_issuer: RTL and testbench

- Command-side front end for the 2-stage pipelined 8-bit ALU (`HW2_alu`).
- Accepts tagged ALU commands over a valid/ready handshake and drives the ALU operand and instruction inputs.
- Tracks in-flight operations, then captures ALU results into a response FIFO that is drained over a second valid/ready handshake.
- Sits between a command producer (sequencer/CPU stub) and a result consumer. Credit-based issue guarantees no result is ever dropped.

---
 rtl/alu_cmd_issuer.sv | 198 +++++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
//   Command-side front end for the 2-stage pipelined 8-bit ALU. Tagged
//   commands are accepted over a valid/ready handshake and registered onto
//   the ALU operand/opcode inputs. A {valid, tag, err} shift register follows
//   each operation through the ALU. When an operation reaches the end of that
//   shift register, its result is pushed into a first-word-fall-through
//   response FIFO. The FIFO is drained over a second valid/ready handshake.
//
//   Issue is credit based: a command is only accepted while
//   (in-flight ops + queued results) < FIFO_DEPTH. Every issued op therefore
//   has a FIFO slot reserved, so the never-stalled tracking pipe can always
//   push its result.
//
// Handshake semantics (both channels):
//   A transfer happens on a rising clk edge where valid && ready. While valid
//   is high and ready is low, the producer holds valid and its payload
//   stable. cmd_ready_o and rsp_valid_o are decoded from registered state
//   only, so neither has a combinational dependency on the opposite side of
//   its handshake.
//
// Ports:
//   clk_p_i, reset_n_i           clock (rising), async active-low reset
//   cmd_valid_i / cmd_ready_o    command handshake
//   cmd_a_i, cmd_b_i             8-bit operands
//   cmd_inst_i                   3-bit opcode (3'b111 is illegal)
//   cmd_tag_i                    command tag, returned with the result
//   alu_a_o, alu_b_o, alu_inst_o registered ALU inputs
//   alu_data_i                   ALU result, ALU_LAT edges after its inputs
//   rsp_valid_o / rsp_ready_i    response handshake
//   rsp_data_o, rsp_tag_o        head-of-FIFO result and tag
//   rsp_err_o                    head result came from an illegal opcode
//   busy_o                       an op is in flight or the FIFO is non-empty
module alu_cmd_issuer #(
  parameter int ALU_LAT    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic             clk_p_i,
  input  logic             reset_n_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [7:0]       cmd_a_i,
  input  logic [7:0]       cmd_b_i,
  input  logic [2:0]       cmd_inst_i,
  input  logic [TAG_W-1:0] cmd_tag_i,
  output logic [7:0]       alu_a_o,
  output logic [7:0]       alu_b_o,
  output logic [2:0]       alu_inst_o,
  input  logic [15:0]      alu_data_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [15:0]      rsp_data_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_err_o,
  output logic             busy_o
);

  // Stage index whose valid bit lines up with the ALU result on alu_data_i.
  localparam int LAST  = ALU_LAT;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Both counters share one width so their sum can be compared directly.
  localparam int CNT_W = $clog2(FIFO_DEPTH + ALU_LAT + 2);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [2:0]       INST_ILLEGAL = 3'b111;

  // ALU input registers
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  logic [2:0] alu_inst_q, alu_inst_d;

  // Tracking pipe
  logic             pipe_v_q   [0:LAST];
  logic             pipe_v_d   [0:LAST];
  logic [TAG_W-1:0] pipe_tag_q [0:LAST];
  logic [TAG_W-1:0] pipe_tag_d [0:LAST];
  logic             pipe_err_q [0:LAST];
  logic             pipe_err_d [0:LAST];

  // Response FIFO storage and pointers
  logic [15:0]      mem_data_q [0:FIFO_DEPTH-1];
  logic [15:0]      mem_data_d [0:FIFO_DEPTH-1];
  logic [TAG_W-1:0] mem_tag_q  [0:FIFO_DEPTH-1];
  logic [TAG_W-1:0] mem_tag_d  [0:FIFO_DEPTH-1];
  logic             mem_err_q  [0:FIFO_DEPTH-1];
  logic             mem_err_d  [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  // Credit counters
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;

  logic accept;
  logic push;
  logic pop;

  // Registered-state decodes
  assign cmd_ready_o = (inflight_q + fifo_cnt_q) < DEPTH_C;
  assign rsp_valid_o = (fifo_cnt_q != '0);
  assign busy_o      = (inflight_q != '0) || (fifo_cnt_q != '0);
  assign rsp_data_o  = mem_data_q[rd_ptr_q];
  assign rsp_tag_o   = mem_tag_q[rd_ptr_q];
  assign rsp_err_o   = mem_err_q[rd_ptr_q];
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_inst_o  = alu_inst_q;

  assign accept = cmd_valid_i && cmd_ready_o;
  assign push   = pipe_v_q[LAST];
  assign pop    = rsp_valid_o && rsp_ready_i;

  always_comb begin
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_inst_d = alu_inst_q;
    pipe_v_d   = pipe_v_q;
    pipe_tag_d = pipe_tag_q;
    pipe_err_d = pipe_err_q;
    mem_data_d = mem_data_q;
    mem_tag_d  = mem_tag_q;
    mem_err_d  = mem_err_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    // ALU inputs hold their last value between accepts.
    if (accept) begin
      alu_a_d    = cmd_a_i;
      alu_b_d    = cmd_b_i;
      alu_inst_d = cmd_inst_i;
    end

    // The tracking pipe shifts every cycle; an idle cycle inserts a bubble.
    pipe_v_d[0]   = accept;
    pipe_tag_d[0] = accept ? cmd_tag_i : '0;
    pipe_err_d[0] = accept && (cmd_inst_i == INST_ILLEGAL);
    for (int i = 1; i <= LAST; i++) begin
      pipe_v_d[i]   = pipe_v_q[i-1];
      pipe_tag_d[i] = pipe_tag_q[i-1];
      pipe_err_d[i] = pipe_err_q[i-1];
    end

    // Capture. An illegal opcode produces an undefined ALU result, so a
    // zero result is stored for it instead.
    if (push) begin
      mem_data_d[wr_ptr_q] = pipe_err_q[LAST] ? 16'h0000 : alu_data_i;
      mem_tag_d[wr_ptr_q]  = pipe_tag_q[LAST];
      mem_err_d[wr_ptr_q]  = pipe_err_q[LAST];
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // A capture moves one credit from in-flight to queued within the same
    // edge, so the total only changes on accept and pop.
    inflight_d = inflight_q + {{(CNT_W-1){1'b0}}, accept}
                            - {{(CNT_W-1){1'b0}}, push};
    fifo_cnt_d = fifo_cnt_q + {{(CNT_W-1){1'b0}}, push}
                            - {{(CNT_W-1){1'b0}}, pop};
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_inst_q <= '0;
      for (int i = 0; i <= LAST; i++) begin
        pipe_v_q[i]   <= 1'b0;
        pipe_tag_q[i] <= '0;
        pipe_err_q[i] <= 1'b0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_tag_q[i]  <= '0;
        mem_err_q[i]  <= 1'b0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      inflight_q <= '0;
    end else begin
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_inst_q <= alu_inst_d;
      pipe_v_q   <= pipe_v_d;
      pipe_tag_q <= pipe_tag_d;
      pipe_err_q <= pipe_err_d;
      mem_data_q <= mem_data_d;
      mem_tag_q  <= mem_tag_d;
      mem_err_q  <= mem_err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer
//   Directed bench for alu_cmd_issuer. A small behavioural stand-in for the
//   2-stage ALU closes the loop between alu_*_o and alu_data_i. Expected
//   responses are hand-computed constants from a vector table. They are
//   queued at command accept and checked in order as responses are popped.
module tb_alu_cmd_issuer;

  localparam int TAG_W = 4;
  localparam int RW    = 16 + TAG_W + 1;

  typedef struct packed {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [2:0]       inst;
    logic [TAG_W-1:0] tag;
    logic [15:0]      data;
    logic             err;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [2:0]       cmd_inst;
  logic [TAG_W-1:0] cmd_tag;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [2:0]       alu_inst;
  logic [15:0]      alu_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [15:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             busy;

  alu_cmd_issuer #(.ALU_LAT(2), .FIFO_DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk_p_i     (clk),
    .reset_n_i   (reset_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_a_i     (cmd_a),
    .cmd_b_i     (cmd_b),
    .cmd_inst_i  (cmd_inst),
    .cmd_tag_i   (cmd_tag),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_inst_o  (alu_inst),
    .alu_data_i  (alu_data),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_tag_o   (rsp_tag),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy)
  );

  // ---------------- ALU stand-in (2 edges input -> data_o) ----------------
  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] inst);
    logic [15:0] r;
    case (inst)
      3'd0:    r = {8'h00, a} + {8'h00, b};
      3'd1:    r = {8'h00, b} - {8'h00, a};
      3'd2:    r = {8'h00, b} * {8'h00, a};
      3'd3:    r = {8'h00, a & b};
      3'd4:    r = {8'h00, a ^ b};
      3'd5:    r = a[7] ? {8'h00, 8'h00 - a} : {8'h00, a};
      3'd6:    r = ({8'h00, b} - {8'h00, a}) << 2;
      default: r = 16'hDEAD;
    endcase
    return r;
  endfunction

  logic [15:0] alu_s1;
  logic [15:0] alu_s2;
  always @(posedge clk) begin
    alu_s1 <= alu_f(alu_a, alu_b, alu_inst);
    alu_s2 <= alu_s1;
  end
  assign alu_data = alu_s2;

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // A pop happens on the next rising edge whenever valid && ready at the
  // preceding falling edge.
  always @(negedge clk) begin
    logic [RW-1:0] e;
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected actual=tag %0d data %h required=no response",
                 rsp_tag, rsp_data);
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(e[RW-1:TAG_W+1]));
        check("rsp_tag",  32'(rsp_tag),  32'(e[TAG_W:1]));
        check("rsp_err",  32'(rsp_err),  32'(e[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns 1 time unit after the accepting edge.
  task automatic send(input vec_t v);
    bit done;
    done      = 1'b0;
    cmd_a     = v.a;
    cmd_b     = v.b;
    cmd_inst  = v.inst;
    cmd_tag   = v.tag;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        exp_q.push_back({v.data, v.tag, v.err});
        done = 1'b1;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=no accept required=accept tag %0d", v.tag);
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) ok = 1'b1;
    end
    check(name, 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // ---------------- vector table ----------------
  vec_t tbl [13];

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   cyc;
    int   acc;
    int   nxt;
    logic rdy;
    vec_t v;

    //           a      b      inst  tag    data      err
    tbl[0]  = '{8'h03, 8'h05, 3'd0, 4'd1,  16'h0008, 1'b0};
    tbl[1]  = '{8'h01, 8'h00, 3'd1, 4'd2,  16'hFFFF, 1'b0};
    tbl[2]  = '{8'hFF, 8'hFF, 3'd2, 4'd3,  16'hFE01, 1'b0};
    tbl[3]  = '{8'hF0, 8'h3C, 3'd3, 4'd4,  16'h0030, 1'b0};
    tbl[4]  = '{8'h07, 8'h05, 3'd0, 4'd5,  16'h000C, 1'b0};
    tbl[5]  = '{8'h07, 8'h09, 3'd7, 4'd6,  16'h0000, 1'b1};
    tbl[6]  = '{8'hAA, 8'h55, 3'd4, 4'd7,  16'h00FF, 1'b0};
    tbl[7]  = '{8'h80, 8'h00, 3'd5, 4'd8,  16'h0080, 1'b0};
    tbl[8]  = '{8'hFF, 8'h12, 3'd5, 4'd9,  16'h0001, 1'b0};
    tbl[9]  = '{8'h01, 8'h00, 3'd6, 4'd10, 16'hFFFC, 1'b0};
    tbl[10] = '{8'h00, 8'hFF, 3'd6, 4'd11, 16'h03FC, 1'b0};
    tbl[11] = '{8'hFF, 8'hFF, 3'd0, 4'd12, 16'h01FE, 1'b0};
    tbl[12] = '{8'h05, 8'h03, 3'd1, 4'd13, 16'hFFFE, 1'b0};

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_inst  = '0;
    cmd_tag   = '0;
    rsp_ready = 1'b0;

    // ---- reset values ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_alu_a",     32'(alu_a),     32'd0);
    check("rst_alu_b",     32'(alu_b),     32'd0);
    check("rst_alu_inst",  32'(alu_inst),  32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_rsp_tag",   32'(rsp_tag),   32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // ---- single ADD: response valid 3 edges after accept ----
    rsp_ready = 1'b1;
    send(tbl[0]);
    check("issued_alu_a",    32'(alu_a),    32'h03);
    check("issued_alu_b",    32'(alu_b),    32'h05);
    check("issued_alu_inst", 32'(alu_inst), 32'd0);
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
      @(posedge clk);
      cyc++;
    end
    check("add_latency", 32'(cyc), 32'd3);
    wait_drain("drain_single");
    check("hold_alu_a", 32'(alu_a), 32'h03);

    // ---- back-to-back: responses in consecutive cycles ----
    for (int i = 1; i <= 3; i++) send(tbl[i]);
    wait_rsp_valid("b2b_first");
    @(negedge clk);
    check("b2b_valid_2", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    check("b2b_valid_3", 32'(rsp_valid), 32'd1);
    wait_drain("drain_b2b");

    // ---- remaining table: illegal opcode, edge operands ----
    for (int i = 4; i < 13; i++) send(tbl[i]);
    wait_drain("drain_table");

    // ---- backpressure: 4 credits, head stable, then in-order drain ----
    rsp_ready = 1'b0;
    nxt       = 0;
    acc       = 0;
    cmd_a     = 8'h00;
    cmd_b     = 8'h10;
    cmd_inst  = 3'd0;
    cmd_tag   = '0;
    cmd_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      rdy = cmd_ready;
      if (rsp_valid && exp_q.size() != 0)
        check("stall_head", 32'({rsp_data, rsp_tag, rsp_err}), 32'(exp_q[0]));
      @(posedge clk);
      if (rdy && cmd_valid) begin
        exp_q.push_back({16'(nxt) + 16'h0010, TAG_W'(nxt), 1'b0});
        nxt++;
        acc++;
      end
      #1;
      if (nxt < 8) begin
        cmd_a   = 8'(nxt);
        cmd_tag = TAG_W'(nxt);
      end else begin
        cmd_valid = 1'b0;
      end
    end
    check("stall_accepts", 32'(acc), 32'd4);
    @(negedge clk);
    check("stall_ready", 32'(cmd_ready), 32'd0);
    check("stall_valid", 32'(rsp_valid), 32'd1);
    check("stall_busy",  32'(busy),      32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int t = nxt; t < 8; t++) begin
      v = '{8'(t), 8'h10, 3'd0, TAG_W'(t), 16'(t) + 16'h0010, 1'b0};
      send(v);
    end
    wait_drain("drain_stall");

    // ---- reset mid-op: 2 in flight, 1 queued ----
    rsp_ready = 1'b0;
    v = '{8'h01, 8'h02, 3'd0, 4'd1, 16'h0003, 1'b0}; send(v);
    v = '{8'h02, 8'h02, 3'd0, 4'd2, 16'h0004, 1'b0}; send(v);
    v = '{8'h03, 8'h02, 3'd0, 4'd3, 16'h0005, 1'b0}; send(v);
    @(posedge clk);
    #1;
    check("prerst_valid", 32'(rsp_valid), 32'd1);
    check("prerst_busy",  32'(busy),      32'd1);
    #3 reset_n = 1'b0;
    #1;
    check("midrst_valid", 32'(rsp_valid), 32'd0);
    check("midrst_busy",  32'(busy),      32'd0);
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    check("midrst_data",  32'(rsp_data),  32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale_valid", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    v = '{8'h01, 8'h01, 3'd0, 4'd9, 16'h0002, 1'b0};
    send(v);
    wait_drain("drain_post_rst");

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
